// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: greedy 25/10/5 payout from three hoppers,
// one coin at a time with eject pulse, ack wait and fault handling.
module change_dispense_ctrl #(
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] change_amt,
   input  logic       coin_ack,
   input  logic       refill_en,
   input  logic [1:0] refill_sel,
   input  logic [7:0] refill_qty,
   input  logic       clear,
   output logic       eject_5,
   output logic       eject_10,
   output logic       eject_25,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [7:0] paid_out,
   output logic [7:0] cnt5,
   output logic [7:0] cnt10,
   output logic [7:0] cnt25
);

   typedef enum logic [2:0] {
      IDLE, CALC, EJECT, WAIT_ACK, DONE, FAULT
   } state_t;

   typedef enum logic [1:0] {
      C_NONE, C_5, C_10, C_25
   } coin_t;

   localparam logic [3:0] P_LAST = 4'(PULSE_CYCLES - 1);
   localparam logic [7:0] T_LAST = 8'(ACK_TIMEOUT - 1);

   state_t     state, state_n;
   coin_t      coin, coin_n;
   logic [7:0] remaining, remaining_n;
   logic [7:0] paid_n;
   logic [7:0] cnt5_n, cnt10_n, cnt25_n;
   logic [3:0] pcnt, pcnt_n;
   logic [7:0] tcnt, tcnt_n;
   logic       e5_n, e10_n, e25_n;
   logic       done_n;
   logic [1:0] code_n;
   logic [7:0] val;

   function automatic logic [7:0] sat_add(input logic [7:0] a,
                                          input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   assign busy  = (state == CALC) || (state == EJECT) ||
                  (state == WAIT_ACK) || (state == DONE);
   assign fault = (state == FAULT);

   always_comb begin
      val = 8'd0;
      unique case (coin)
         C_5:     val = 8'd5;
         C_10:    val = 8'd10;
         C_25:    val = 8'd25;
         default: val = 8'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         coin       <= C_NONE;
         remaining  <= 8'd0;
         paid_out   <= 8'd0;
         cnt5       <= 8'd0;
         cnt10      <= 8'd0;
         cnt25      <= 8'd0;
         pcnt       <= 4'd0;
         tcnt       <= 8'd0;
         eject_5    <= 1'b0;
         eject_10   <= 1'b0;
         eject_25   <= 1'b0;
         done       <= 1'b0;
         fault_code <= 2'd0;
      end else begin
         state      <= state_n;
         coin       <= coin_n;
         remaining  <= remaining_n;
         paid_out   <= paid_n;
         cnt5       <= cnt5_n;
         cnt10      <= cnt10_n;
         cnt25      <= cnt25_n;
         pcnt       <= pcnt_n;
         tcnt       <= tcnt_n;
         eject_5    <= e5_n;
         eject_10   <= e10_n;
         eject_25   <= e25_n;
         done       <= done_n;
         fault_code <= code_n;
      end
   end

   always_comb begin
      state_n     = state;
      coin_n      = coin;
      remaining_n = remaining;
      paid_n      = paid_out;
      cnt5_n      = cnt5;
      cnt10_n     = cnt10;
      cnt25_n     = cnt25;
      pcnt_n      = pcnt;
      tcnt_n      = tcnt;
      e5_n        = 1'b0;
      e10_n       = 1'b0;
      e25_n       = 1'b0;
      done_n      = 1'b0;
      code_n      = fault_code;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (change_amt == 8'd0) begin
                  paid_n  = 8'd0;
                  done_n  = 1'b1;
                  state_n = DONE;
               end else if ((change_amt % 8'd5) != 8'd0) begin
                  code_n  = 2'd3;
                  state_n = FAULT;
               end else begin
                  remaining_n = change_amt;
                  paid_n      = 8'd0;
                  state_n     = CALC;
               end
            end
         end
         CALC: begin
            pcnt_n  = 4'd0;
            state_n = EJECT;
            // remaining is a nonzero multiple of 5 here, so a 5c always fits
            if (remaining >= 8'd25 && cnt25 != 8'd0) begin
               coin_n = C_25;
               e25_n  = 1'b1;
            end else if (remaining >= 8'd10 && cnt10 != 8'd0) begin
               coin_n = C_10;
               e10_n  = 1'b1;
            end else if (cnt5 != 8'd0) begin
               coin_n = C_5;
               e5_n   = 1'b1;
            end else begin
               coin_n  = C_NONE;
               code_n  = 2'd1;
               state_n = FAULT;
            end
         end
         EJECT: begin
            if (pcnt == P_LAST) begin
               tcnt_n  = 8'd0;
               state_n = WAIT_ACK;
            end else begin
               pcnt_n = pcnt + 4'd1;
               e5_n   = (coin == C_5);
               e10_n  = (coin == C_10);
               e25_n  = (coin == C_25);
            end
         end
         WAIT_ACK: begin
            if (coin_ack) begin
               remaining_n = remaining - val;
               paid_n      = paid_out + val;
               if (coin == C_5 && cnt5 != 8'd0)
                  cnt5_n = cnt5 - 8'd1;
               if (coin == C_10 && cnt10 != 8'd0)
                  cnt10_n = cnt10 - 8'd1;
               if (coin == C_25 && cnt25 != 8'd0)
                  cnt25_n = cnt25 - 8'd1;
               if (remaining == val) begin
                  done_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  state_n = CALC;
               end
            end else if (tcnt == T_LAST) begin
               code_n  = 2'd2;
               state_n = FAULT;
            end else begin
               tcnt_n = tcnt + 8'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         FAULT: begin
            if (clear) begin
               code_n  = 2'd0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // hoppers only change by refill while idle or faulted
      if (!busy && refill_en) begin
         unique case (refill_sel)
            2'd0:    cnt5_n  = sat_add(cnt5, refill_qty);
            2'd1:    cnt10_n = sat_add(cnt10, refill_qty);
            2'd2:    cnt25_n = sat_add(cnt25, refill_qty);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: payout sequences, faults,
// refill rules and asynchronous reset.
module tb_change_dispense_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] change_amt;
   logic       coin_ack;
   logic       refill_en;
   logic [1:0] refill_sel;
   logic [7:0] refill_qty;
   logic       clear;
   logic       eject_5, eject_10, eject_25;
   logic       busy, done, fault;
   logic [1:0] fault_code;
   logic [7:0] paid_out, cnt5, cnt10, cnt25;

   int n_run  = 0;
   int n_fail = 0;

   int coin_seq[$];
   int width_seq[$];
   int done_at, fault_at, fall_at, multi, ended;
   bit busy_refill = 0;

   change_dispense_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .change_amt (change_amt),
      .coin_ack   (coin_ack),
      .refill_en  (refill_en),
      .refill_sel (refill_sel),
      .refill_qty (refill_qty),
      .clear      (clear),
      .eject_5    (eject_5),
      .eject_10   (eject_10),
      .eject_25   (eject_25),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .fault_code (fault_code),
      .paid_out   (paid_out),
      .cnt5       (cnt5),
      .cnt10      (cnt10),
      .cnt25      (cnt25)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      start      = 1'b0;
      change_amt = 8'd0;
      coin_ack   = 1'b0;
      refill_en  = 1'b0;
      refill_sel = 2'd0;
      refill_qty = 8'd0;
      clear      = 1'b0;
      #12;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic refill(input logic [1:0] sel, input logic [7:0] qty);
      @(negedge clk);
      refill_en  = 1'b1;
      refill_sel = sel;
      refill_qty = qty;
      @(negedge clk);
      refill_en  = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pay(input logic [7:0] amt, input bit ack_on);
      int w;
      int cur;
      coin_seq.delete();
      width_seq.delete();
      w = 0; cur = 0;
      done_at = -1; fault_at = -1; fall_at = -1;
      multi = 0; ended = 0;
      @(negedge clk);
      start      = 1'b1;
      change_amt = amt;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2000 && ended == 0; i++) begin
         coin_ack  = 1'b0;
         refill_en = 1'b0;
         if (busy_refill && busy) begin
            refill_en  = 1'b1;
            refill_sel = 2'd1;
            refill_qty = 8'd5;
         end
         if ((int'(eject_5) + int'(eject_10) + int'(eject_25)) > 1)
            multi = 1;
         if (eject_5 || eject_10 || eject_25) begin
            cur = eject_5 ? 5 : (eject_10 ? 10 : 25);
            w++;
         end else if (w != 0) begin
            coin_seq.push_back(cur);
            width_seq.push_back(w);
            w = 0;
            fall_at = i;
            if (ack_on) coin_ack = 1'b1;
         end
         if (done) begin
            done_at = i;
            ended = 1;
         end
         if (fault) begin
            fault_at = i;
            ended = 1;
         end
         if (ended == 0) @(negedge clk);
      end
      coin_ack  = 1'b0;
      refill_en = 1'b0;
      chk("payout_ended", ended, 1);
      chk("one_eject_at_a_time", multi, 0);
   endtask

   initial begin
      do_reset();
      // reset state
      chk("rst_busy", int'(busy), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_code", int'(fault_code), 0);
      chk("rst_paid", int'(paid_out), 0);
      chk("rst_cnt5", int'(cnt5), 0);
      chk("rst_ej", int'({eject_5, eject_10, eject_25}), 0);

      // greedy 40c = 25 + 10 + 5
      refill(2'd0, 8'd10);
      refill(2'd1, 8'd10);
      refill(2'd2, 8'd10);
      chk("refill_cnt25", int'(cnt25), 10);
      pay(8'd40, 1'b1);
      chk("p40_n", coin_seq.size(), 3);
      if (coin_seq.size() == 3) begin
         chk("p40_c0", coin_seq[0], 25);
         chk("p40_c1", coin_seq[1], 10);
         chk("p40_c2", coin_seq[2], 5);
         chk("p40_w0", width_seq[0], 4);
         chk("p40_w1", width_seq[1], 4);
         chk("p40_w2", width_seq[2], 4);
      end
      chk("p40_done", int'(done_at >= 0), 1);
      chk("p40_paid", int'(paid_out), 40);
      chk("p40_cnt5", int'(cnt5), 9);
      chk("p40_cnt10", int'(cnt10), 9);
      chk("p40_cnt25", int'(cnt25), 9);
      @(negedge clk);
      chk("p40_idle", int'(busy), 0);
      chk("p40_done_1cyc", int'(done), 0);

      // only 5c coins available
      do_reset();
      refill(2'd0, 8'd6);
      pay(8'd30, 1'b1);
      chk("p30_n", coin_seq.size(), 6);
      for (int k = 0; k < coin_seq.size(); k++) begin
         chk("p30_coin", coin_seq[k], 5);
      end
      chk("p30_done", int'(done_at >= 0), 1);
      chk("p30_paid", int'(paid_out), 30);
      chk("p30_cnt5", int'(cnt5), 0);

      // runs out of change mid-payout
      do_reset();
      refill(2'd0, 8'd1);
      pay(8'd20, 1'b1);
      chk("p20_n", coin_seq.size(), 1);
      chk("p20_fault", int'(fault), 1);
      chk("p20_code", int'(fault_code), 1);
      chk("p20_paid", int'(paid_out), 5);
      chk("p20_busy", int'(busy), 0);
      do_clear();
      chk("p20_clr_fault", int'(fault), 0);
      chk("p20_clr_code", int'(fault_code), 0);
      chk("p20_clr_busy", int'(busy), 0);

      // ack timeout
      do_reset();
      refill(2'd1, 8'd1);
      refill(2'd0, 8'd1);
      pay(8'd15, 1'b0);
      chk("p15_n", coin_seq.size(), 1);
      if (coin_seq.size() == 1) chk("p15_coin", coin_seq[0], 10);
      chk("p15_code", int'(fault_code), 2);
      chk("p15_delay", fault_at - fall_at, 255);
      chk("p15_cnt10", int'(cnt10), 1);
      chk("p15_paid", int'(paid_out), 0);
      do_clear();

      // non-multiple of 5, then zero amount
      pay(8'd12, 1'b1);
      chk("p12_code", int'(fault_code), 3);
      chk("p12_n", coin_seq.size(), 0);
      chk("p12_at", fault_at, 0);
      do_clear();
      pay(8'd0, 1'b1);
      chk("p0_done_at", done_at, 0);
      chk("p0_n", coin_seq.size(), 0);
      chk("p0_paid", int'(paid_out), 0);

      // reset during EJECT
      do_reset();
      refill(2'd2, 8'd2);
      @(negedge clk);
      start      = 1'b1;
      change_amt = 8'd25;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !eject_25; i++) @(negedge clk);
      chk("rst_mid_ej_on", int'(eject_25), 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_ej_off", int'(eject_25), 0);
      chk("rst_mid_busy", int'(busy), 0);
      #2;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_cnt25", int'(cnt25), 0);
      chk("rst_mid_paid", int'(paid_out), 0);
      chk("rst_mid_idle", int'(busy), 0);

      // refill while busy is ignored
      refill(2'd1, 8'd2);
      busy_refill = 1;
      pay(8'd10, 1'b1);
      busy_refill = 0;
      @(negedge clk);
      chk("busy_refill_cnt10", int'(cnt10), 1);
      chk("busy_refill_paid", int'(paid_out), 10);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
